// File: rtl/riscv_defines.sv
// Shared definitions for the write-back stage and its load/store alignment
// helper: datapath widths, memory access size encodings and the write-back
// controller state type.
package riscv_defines;

  localparam int unsigned WORD_WIDTH     = 32;
  localparam int unsigned REG_ADDR_WIDTH = 5;

  // Encoding of mem_size_i; MEM_ILLEGAL is always reported as misaligned.
  typedef enum logic [1:0] {
    MEM_BYTE    = 2'b00,
    MEM_HALF    = 2'b01,
    MEM_WORD    = 2'b10,
    MEM_ILLEGAL = 2'b11
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    REQ     = 2'b01,
    WAIT_RV = 2'b10
  } wb_state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational load/store alignment helper.
//   offset_i      byte offset within the word (addr[1:0])
//   size_i        access size (byte/half/word/illegal)
//   sign_ext_i    sign-extend byte/half loads when set, zero-extend otherwise
//   store_data_i  raw store operand (rs2)
//   rdata_i       raw word returned by data memory
//   be_o          byte enables for the access
//   wdata_o       store data replicated across the byte lanes
//   load_data_o   selected and extended load value
//   misaligned_o  access violates natural alignment or uses an illegal size
module lsu_align
  import riscv_defines::*;
(
  input  logic [1:0]  offset_i,
  input  logic [1:0]  size_i,
  input  logic        sign_ext_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_data_o,
  output logic        misaligned_o
);

  logic [31:0] lane;

  always_comb begin
    be_o         = '0;
    wdata_o      = store_data_i;
    misaligned_o = 1'b0;
    case (mem_size_t'(size_i))
      MEM_BYTE: begin
        be_o    = 4'b0001 << offset_i;
        wdata_o = {4{store_data_i[7:0]}};
      end
      MEM_HALF: begin
        be_o         = offset_i[1] ? 4'b1100 : 4'b0011;
        wdata_o      = {2{store_data_i[15:0]}};
        misaligned_o = offset_i[0];
      end
      MEM_WORD: begin
        be_o         = 4'b1111;
        misaligned_o = (offset_i != 2'b00);
      end
      default: misaligned_o = 1'b1;
    endcase
  end

  // Shift the addressed byte/half down to bit 0 before extension.
  assign lane = rdata_i >> {offset_i, 3'b000};

  always_comb begin
    load_data_o = rdata_i;
    case (mem_size_t'(size_i))
      MEM_BYTE: load_data_o = {{24{sign_ext_i & lane[7]}}, lane[7:0]};
      MEM_HALF: load_data_o = {{16{sign_ext_i & lane[15]}}, lane[15:0]};
      default:  load_data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: retires one instruction at a time from execute and drives
// the register-bank write port. ALU results are written back one cycle after
// acceptance; loads/stores run a req/gnt/rvalid data-memory transaction and
// stall execute (ex_ready_o low) until the response arrives.
//   clk, rst_n             clock, asynchronous active-low reset
//   ex_valid_i/ex_ready_o  execute handshake
//   alu_result_i           ALU result or byte address for memory ops
//   store_data_i           store operand
//   rd_addr_i, regwrite_en_i, mem_load_i, mem_store_i, mem_size_i,
//   mem_sign_ext_i         decoded instruction attributes
//   data_*                 data-memory request/response interface
//   wdata_wb_o, waddr_wb_o, wen_wb_o  register-bank write port
//   misaligned_o           one-cycle pulse for misaligned/illegal accesses
module wb_stage #(
  parameter int unsigned WORD_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ex_valid_i,
  output logic                      ex_ready_o,
  input  logic [WORD_WIDTH-1:0]     alu_result_i,
  input  logic [WORD_WIDTH-1:0]     store_data_i,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr_i,
  input  logic                      regwrite_en_i,
  input  logic                      mem_load_i,
  input  logic                      mem_store_i,
  input  logic [1:0]                mem_size_i,
  input  logic                      mem_sign_ext_i,
  output logic                      data_req_o,
  input  logic                      data_gnt_i,
  input  logic                      data_rvalid_i,
  output logic [WORD_WIDTH-1:0]     data_addr_o,
  output logic                      data_we_o,
  output logic [3:0]                data_be_o,
  output logic [WORD_WIDTH-1:0]     data_wdata_o,
  input  logic [WORD_WIDTH-1:0]     data_rdata_i,
  output logic [WORD_WIDTH-1:0]     wdata_wb_o,
  output logic [REG_ADDR_WIDTH-1:0] waddr_wb_o,
  output logic                      wen_wb_o,
  output logic                      misaligned_o
);
  import riscv_defines::*;

  wb_state_t                 state_q, state_d;
  logic [WORD_WIDTH-1:0]     addr_q, addr_d;
  logic                      we_q, we_d;
  logic [3:0]                be_q, be_d;
  logic [WORD_WIDTH-1:0]     wdata_q, wdata_d;
  logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
  logic                      load_q, load_d;
  logic [1:0]                size_q, size_d;
  logic                      sext_q, sext_d;
  logic [1:0]                off_q, off_d;
  logic                      wen_q, wen_d;
  logic [WORD_WIDTH-1:0]     wb_data_q, wb_data_d;
  logic [REG_ADDR_WIDTH-1:0] wb_addr_q, wb_addr_d;
  logic                      mis_q, mis_d;

  logic                      sel_idle;
  logic [1:0]                al_off, al_size;
  logic                      al_sext;
  logic [3:0]                al_be;
  logic [WORD_WIDTH-1:0]     al_wdata, al_load;
  logic                      al_mis;

  // One aligner serves both directions: live inputs while IDLE (request
  // formation, misalignment check), captured attributes while a load is
  // outstanding (response extraction).
  assign sel_idle = (state_q == IDLE);
  assign al_off   = sel_idle ? alu_result_i[1:0] : off_q;
  assign al_size  = sel_idle ? mem_size_i        : size_q;
  assign al_sext  = sel_idle ? mem_sign_ext_i    : sext_q;

  lsu_align u_align (
    .offset_i     (al_off),
    .size_i       (al_size),
    .sign_ext_i   (al_sext),
    .store_data_i (store_data_i),
    .rdata_i      (data_rdata_i),
    .be_o         (al_be),
    .wdata_o      (al_wdata),
    .load_data_o  (al_load),
    .misaligned_o (al_mis)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    we_d      = we_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    rd_d      = rd_q;
    load_d    = load_q;
    size_d    = size_q;
    sext_d    = sext_q;
    off_d     = off_q;
    wb_data_d = wb_data_q;
    wb_addr_d = wb_addr_q;
    wen_d     = 1'b0;
    mis_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (ex_valid_i) begin
          if (mem_load_i || mem_store_i) begin
            if (al_mis) begin
              mis_d = 1'b1;
            end else begin
              state_d = REQ;
              addr_d  = {alu_result_i[WORD_WIDTH-1:2], 2'b00};
              // A load takes precedence when both flags are set.
              we_d    = mem_store_i && !mem_load_i;
              be_d    = al_be;
              wdata_d = al_wdata;
              rd_d    = rd_addr_i;
              load_d  = mem_load_i;
              size_d  = mem_size_i;
              sext_d  = mem_sign_ext_i;
              off_d   = alu_result_i[1:0];
            end
          end else if (regwrite_en_i && (rd_addr_i != '0)) begin
            wen_d     = 1'b1;
            wb_data_d = alu_result_i;
            wb_addr_d = rd_addr_i;
          end
        end
      end
      REQ: begin
        if (data_gnt_i) state_d = WAIT_RV;
      end
      WAIT_RV: begin
        if (data_rvalid_i) begin
          state_d = IDLE;
          if (load_q && (rd_q != '0)) begin
            wen_d     = 1'b1;
            wb_data_d = al_load;
            wb_addr_d = rd_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      we_q      <= 1'b0;
      be_q      <= '0;
      wdata_q   <= '0;
      rd_q      <= '0;
      load_q    <= 1'b0;
      size_q    <= '0;
      sext_q    <= 1'b0;
      off_q     <= '0;
      wen_q     <= 1'b0;
      wb_data_q <= '0;
      wb_addr_q <= '0;
      mis_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      rd_q      <= rd_d;
      load_q    <= load_d;
      size_q    <= size_d;
      sext_q    <= sext_d;
      off_q     <= off_d;
      wen_q     <= wen_d;
      wb_data_q <= wb_data_d;
      wb_addr_q <= wb_addr_d;
      mis_q     <= mis_d;
    end
  end

  assign ex_ready_o   = (state_q == IDLE);
  assign data_req_o   = (state_q == REQ);
  assign data_addr_o  = addr_q;
  assign data_we_o    = we_q;
  assign data_be_o    = be_q;
  assign data_wdata_o = wdata_q;
  assign wdata_wb_o   = wb_data_q;
  assign waddr_wb_o   = wb_addr_q;
  assign wen_wb_o     = wen_q;
  assign misaligned_o = mis_q;

endmodule
